// File: rtl/mode_pkg.sv
// ============================================================================
// Module   : mode_pkg
// Purpose  : Shared constants and debounce state encoding for the mode/display
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mode_pkg;

    localparam logic SEG_BLANK = 1'b0;
    localparam logic COM_OFF   = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } deb_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Two-flop synchroniser and debounce FSM for the mode button.
//            Long-press detection and release pulse exist only when
//            MODE_LONGPRESS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import mode_pkg::*;
#(
    parameter int DEB_CYCLES  = 20
`ifdef MODE_LONGPRESS_EN
    ,
    parameter int LONG_CYCLES = 1000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
`ifdef MODE_LONGPRESS_EN
    output logic long_o,
    output logic release_o,
`endif
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
`ifdef MODE_LONGPRESS_EN
    logic          rel_q, rel_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
`ifdef MODE_LONGPRESS_EN
            rel_q   <= 1'b0;
`endif
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
`ifdef MODE_LONGPRESS_EN
            rel_q   <= rel_d;
`endif
        end
    end

    // cnt_q holds how many consecutive qualifying samples preceded this one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
`ifdef MODE_LONGPRESS_EN
        rel_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    cnt_d = CW'(1);
                    if (DEB_CYCLES <= 1) begin
                        state_d = HELD;
                        press_d = 1'b1;
                    end else begin
                        state_d = DEB_PRESS;
                    end
                end
            end
            DEB_PRESS: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    state_d = HELD;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    cnt_d = CW'(1);
                    if (DEB_CYCLES <= 1) begin
                        state_d = IDLE;
`ifdef MODE_LONGPRESS_EN
                        rel_d   = 1'b1;
`endif
                    end else begin
                        state_d = DEB_REL;
                    end
                end
            end
            DEB_REL: begin
                if (sync2_q) begin
                    state_d = HELD;
                end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                    state_d = IDLE;
`ifdef MODE_LONGPRESS_EN
                    rel_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign press_o = press_q;

`ifdef MODE_LONGPRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);

    logic [LW-1:0] long_cnt_q, long_cnt_d;
    logic          long_done_q, long_done_d;
    logic          long_q, long_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            long_cnt_q  <= long_cnt_d;
            long_done_q <= long_done_d;
            long_q      <= long_d;
        end
    end

    // Hold time accumulates across release bounces; only a full release clears it
    always_comb begin
        long_cnt_d  = long_cnt_q;
        long_done_d = long_done_q;
        long_d      = 1'b0;
        if (state_q == IDLE) begin
            long_cnt_d  = '0;
            long_done_d = 1'b0;
        end else if (state_q == HELD && !long_done_q) begin
            if (long_cnt_q == LW'(LONG_CYCLES - 1)) begin
                long_d      = 1'b1;
                long_done_d = 1'b1;
            end else begin
                long_cnt_d = long_cnt_q + LW'(1);
            end
        end
    end

    assign long_o    = long_q;
    assign release_o = rel_q;
`endif

endmodule

`default_nettype wire

// File: rtl/mode_display_ctrl.sv
// ============================================================================
// Module   : mode_display_ctrl
// Purpose  : Mode sequencer over a runtime enable mask plus registered
//            7-segment source mux with blanking on mode change.
//            Optional long-press-to-mode-0: define MODE_LONGPRESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mode_display_ctrl
    import mode_pkg::*;
#(
    parameter int N_MODES      = 3,
    parameter int SEG_W        = 8,
    parameter int COM_W        = 8,
    parameter int DEB_CYCLES   = 20,
    parameter int BLANK_CYCLES = 2,
    parameter int LONG_CYCLES  = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode_btn,
    input  logic [N_MODES-1:0]         mode_en,
    input  logic [N_MODES*SEG_W-1:0]   ch_seg_data,
    input  logic [N_MODES*COM_W-1:0]   ch_seg_com,
    output logic [SEG_W-1:0]           seg_data,
    output logic [COM_W-1:0]           seg_com,
    output logic [$clog2(N_MODES)-1:0] mode_idx,
    output logic                       mode_chg
);

    localparam int IDX_W = $clog2(N_MODES);
    localparam int BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    if (N_MODES < 2 || N_MODES > 8 || DEB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
        $error("mode_display_ctrl: parameter out of range");
    end

    logic             press_p;
    logic [IDX_W-1:0] mode_idx_q, mode_idx_d;
    logic             mode_chg_q, mode_chg_d;
    logic [BLK_W-1:0] blank_q, blank_d;
    logic [SEG_W-1:0] seg_data_q, seg_data_d;
    logic [COM_W-1:0] seg_com_q, seg_com_d;
    logic [IDX_W-1:0] next_idx;

`ifdef MODE_LONGPRESS_EN
    logic long_p, rel_p;
    logic long_seen_q, long_seen_d;

    btn_debounce #(
        .DEB_CYCLES  (DEB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_btn (
        .clk       (clk),
        .rst_n     (rst),
        .btn_i     (mode_btn),
        .long_o    (long_p),
        .release_o (rel_p),
        .press_o   (press_p)
    );
`else
    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst),
        .btn_i   (mode_btn),
        .press_o (press_p)
    );
`endif

    // First enabled index after the current one, cyclic; holds if none
    always_comb begin
        int j;
        j        = 0;
        next_idx = mode_idx_q;
        for (int k = N_MODES - 1; k >= 1; k--) begin
            j = int'(mode_idx_q) + k;
            if (j >= N_MODES) begin
                j = j - N_MODES;
            end
            if (mode_en[j]) begin
                next_idx = IDX_W'(j);
            end
        end
    end

    always_comb begin
        mode_idx_d = mode_idx_q;
`ifdef MODE_LONGPRESS_EN
        long_seen_d = long_seen_q;
        if (press_p) begin
            long_seen_d = 1'b0;
        end
        if (long_p) begin
            long_seen_d = 1'b1;
        end
`endif
        // A forced jump off a disabled mode swallows any same-cycle press
        if (mode_en == '0) begin
            mode_idx_d = '0;
        end else if (!mode_en[mode_idx_q]) begin
            mode_idx_d = next_idx;
`ifdef MODE_LONGPRESS_EN
        end else if (long_p && mode_en[0]) begin
            mode_idx_d = '0;
        end else if (rel_p && !long_seen_q) begin
            mode_idx_d = next_idx;
`else
        end else if (press_p) begin
            mode_idx_d = next_idx;
`endif
        end
        mode_chg_d = (mode_idx_d != mode_idx_q);
    end

    always_comb begin
        blank_d = blank_q;
        if (mode_chg_d) begin
            blank_d = BLK_W'(BLANK_CYCLES);
        end else if (blank_q != '0) begin
            blank_d = blank_q - BLK_W'(1);
        end
    end

    always_comb begin
        seg_data_d = ch_seg_data[int'(mode_idx_q)*SEG_W +: SEG_W];
        seg_com_d  = ch_seg_com[int'(mode_idx_q)*COM_W +: COM_W];
        if (blank_q != '0 || mode_en == '0) begin
            seg_data_d = {SEG_W{SEG_BLANK}};
            seg_com_d  = {COM_W{COM_OFF}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_idx_q <= '0;
            mode_chg_q <= 1'b0;
            blank_q    <= '0;
            seg_data_q <= {SEG_W{SEG_BLANK}};
            seg_com_q  <= {COM_W{COM_OFF}};
        end else begin
            mode_idx_q <= mode_idx_d;
            mode_chg_q <= mode_chg_d;
            blank_q    <= blank_d;
            seg_data_q <= seg_data_d;
            seg_com_q  <= seg_com_d;
        end
    end

`ifdef MODE_LONGPRESS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_seen_q <= 1'b0;
        end else begin
            long_seen_q <= long_seen_d;
        end
    end
`endif

    assign seg_data = seg_data_q;
    assign seg_com  = seg_com_q;
    assign mode_idx = mode_idx_q;
    assign mode_chg = mode_chg_q;

endmodule

`default_nettype wire

// File: tb/tb_mode_display_ctrl.sv
// ============================================================================
// Module   : tb_mode_display_ctrl
// Purpose  : Self-checking bench for mode_display_ctrl (default build) with a
//            behavioural reference model and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mode_display_ctrl;

    localparam int N   = 3;
    localparam int SW  = 8;
    localparam int CWD = 8;
    localparam int DEB = 20;
    localparam int BLK = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            mode_btn = 1'b0;
    logic [N-1:0]    mode_en = '1;
    logic [N*SW-1:0] ch_seg_data;
    logic [N*CWD-1:0] ch_seg_com;
    logic [SW-1:0]   seg_data;
    logic [CWD-1:0]  seg_com;
    logic [1:0]      mode_idx;
    logic            mode_chg;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;
    bit rnd_ch      = 1'b0;
    int chg_cnt     = 0;

    logic [7:0] dat_tab [N] = '{8'h3F, 8'h06, 8'h5B};
    logic [7:0] com_tab [N] = '{8'hFE, 8'hFD, 8'hFB};

    always #5 clk = ~clk;

    mode_display_ctrl #(
        .N_MODES      (N),
        .SEG_W        (SW),
        .COM_W        (CWD),
        .DEB_CYCLES   (DEB),
        .BLANK_CYCLES (BLK),
        .LONG_CYCLES  (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_btn    (mode_btn),
        .mode_en     (mode_en),
        .ch_seg_data (ch_seg_data),
        .ch_seg_com  (ch_seg_com),
        .seg_data    (seg_data),
        .seg_com     (seg_com),
        .mode_idx    (mode_idx),
        .mode_chg    (mode_chg)
    );

    // Reference model: button level flips after DEB consecutive disagreeing
    // samples seen two cycles late; the accepted press acts one cycle later.
    int         d1, d2, deb, run, pressp;
    int         m_idx, m_chg, m_blank;
    logic [7:0] m_seg, m_com;

    function automatic int next_en(int idx, logic [N-1:0] en);
        for (int k = 1; k < N; k++) begin
            int j = (idx + k) % N;
            if (en[j]) return j;
        end
        return idx;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d1 = 0; d2 = 0; deb = 0; run = 0; pressp = 0;
            m_idx = 0; m_chg = 0; m_blank = 0;
            m_seg = 8'h00; m_com = 8'hFF;
        end else begin
            int s, nidx;
            if (m_blank > 0 || mode_en == '0) begin
                m_seg = 8'h00; m_com = 8'hFF;
            end else begin
                m_seg = ch_seg_data[m_idx*SW +: SW];
                m_com = ch_seg_com[m_idx*CWD +: CWD];
            end
            nidx = m_idx;
            if (mode_en == '0)              nidx = 0;
            else if (!mode_en[m_idx])       nidx = next_en(m_idx, mode_en);
            else if (pressp != 0)           nidx = next_en(m_idx, mode_en);
            m_chg = (nidx != m_idx) ? 1 : 0;
            if (m_chg != 0)                 m_blank = BLK;
            else if (m_blank > 0)           m_blank = m_blank - 1;
            m_idx = nidx;
            s = d2; d2 = d1; d1 = int'(mode_btn);
            pressp = 0;
            if (s != deb) begin
                run = run + 1;
                if (run == DEB) begin
                    deb = s; run = 0; pressp = s;
                end
            end else begin
                run = 0;
            end
        end
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("seg_data", 32'(seg_data), 32'(m_seg));
            check("seg_com",  32'(seg_com),  32'(m_com));
            check("mode_idx", 32'(mode_idx), 32'(m_idx));
            check("mode_chg", 32'(mode_chg), 32'(m_chg));
            if (mode_chg === 1'b1) chg_cnt++;
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (rnd_ch) begin
                for (int i = 0; i < N; i++) begin
                    ch_seg_data[i*SW +: SW]   = 8'($urandom);
                    ch_seg_com[i*CWD +: CWD]  = 8'($urandom);
                end
            end
        end
    endtask

    task automatic press(int hold);
        mode_btn = 1'b1;
        tick(hold);
        mode_btn = 1'b0;
        tick(DEB + 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            ch_seg_data[i*SW +: SW]  = dat_tab[i];
            ch_seg_com[i*CWD +: CWD] = com_tab[i];
        end
        rst = 1'b0;
        mode_en = 3'b111;
        tick(3);
        chk_en = 1'b1;
        check("rst_seg_com",  32'(seg_com),  32'hFF);
        check("rst_seg_data", 32'(seg_data), 32'h00);
        check("rst_mode_idx", 32'(mode_idx), 32'd0);
        rst = 1'b1;
        tick(1);
        check("ch0_after_rst", 32'(seg_data), 32'h3F);

        // Three clean presses with latency and blanking pinned
        for (int p = 0; p < 3; p++) begin
            int n, c0, nw;
            c0 = chg_cnt;
            nw = (p + 1) % N;
            mode_btn = 1'b1;
            n = 0;
            do begin
                @(posedge clk); #1; n++;
            end while (mode_chg !== 1'b1 && n < 60);
            check("press_latency", 32'(n), 32'd23);
            check("idx_after_press", 32'(mode_idx), 32'(nw));
            @(posedge clk); #1;
            check("blank1_com", 32'(seg_com), 32'hFF);
            @(posedge clk); #1;
            check("blank2_com", 32'(seg_com), 32'hFF);
            @(posedge clk); #1;
            check("new_ch_com", 32'(seg_com), 32'(com_tab[nw]));
            #1;
            tick(4);
            mode_btn = 1'b0;
            tick(DEB + 8);
            check("one_chg_pulse", 32'(chg_cnt - c0), 32'd1);
        end

        // Bounce rejection
        for (int b = 0; b < 4; b++) begin
            mode_btn = 1'b1; tick(5);
            mode_btn = 1'b0; tick(5);
        end
        tick(30);
        check("bounce_no_adv", 32'(mode_idx), 32'd0);
        press(25);
        check("after_bounce_press", 32'(mode_idx), 32'd1);

        // Sparse mask
        mode_en = 3'b101;
        tick(1);
        check("mask_jump_idx", 32'(mode_idx), 32'd2);
        check("mask_jump_chg", 32'(mode_chg), 32'd1);
        tick(5);
        press(25);
        check("mask_wrap0", 32'(mode_idx), 32'd0);
        press(25);
        check("mask_skip1", 32'(mode_idx), 32'd2);
        press(25);
        check("mask_back0", 32'(mode_idx), 32'd0);
        mode_en = 3'b100;
        tick(1);
        check("clr_bit0_idx", 32'(mode_idx), 32'd2);
        check("clr_bit0_chg", 32'(mode_chg), 32'd1);
        tick(5);
        press(25);
        check("single_mode_hold", 32'(mode_idx), 32'd2);

        // Zero mask
        mode_en = 3'b000;
        tick(1);
        check("zero_mask_idx", 32'(mode_idx), 32'd0);
        tick(1);
        check("zero_mask_com", 32'(seg_com), 32'hFF);
        check("zero_mask_dat", 32'(seg_data), 32'h00);
        press(25);
        check("zero_mask_press", 32'(mode_idx), 32'd0);
        mode_en = 3'b010;
        tick(1);
        check("restore_idx", 32'(mode_idx), 32'd1);
        tick(5);

        // Randomized phase
        rnd_ch = 1'b1;
        for (int r = 0; r < 120; r++) begin
            int act;
            act = int'($urandom_range(0, 9));
            if (act == 0) begin
                mode_en = 3'($urandom);
            end else if (act == 1) begin
                mode_en = 3'($urandom_range(1, 7));
            end else if (act == 2) begin
                rst = 1'b0;
                #1;
                check("async_rst_com", 32'(seg_com),  32'hFF);
                check("async_rst_dat", 32'(seg_data), 32'h00);
                check("async_rst_idx", 32'(mode_idx), 32'd0);
                tick(2);
                rst = 1'b1;
            end
            mode_btn = 1'b1;
            tick(int'($urandom_range(1, 40)));
            mode_btn = 1'b0;
            tick(int'($urandom_range(1, 40)));
        end
        tick(DEB + 10);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
